// File: rtl/line_buffer_param.sv
// Sliding vertical window over a raster pixel stream: NUM_LINES-1 line memories deliver a
// column of NUM_LINES taps per pixel. Define LB_BORDER_REPLICATE_EN to replicate the oldest valid line into missing taps.
module line_buffer_param #(
    parameter int DATA_W    = 8,
    parameter int PIC_WIDTH = 320,
    parameter int NUM_LINES = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          valid_in,
    input  logic [DATA_W-1:0]             din,
    output logic                          valid_out,
    output logic [NUM_LINES*DATA_W-1:0]   taps,
    output logic [$clog2(PIC_WIDTH)-1:0]  col_out,
    output logic                          eol_out,
    output logic                          win_valid
);

    localparam int COL_W = $clog2(PIC_WIDTH);
    localparam int LF_W  = $clog2(NUM_LINES);

    logic [COL_W-1:0]          col;
    logic [LF_W-1:0]           lines_filled;
    logic                      accept;
    logic                      last_col;
    logic                      lines_full;
    logic [DATA_W-1:0]         rd_data [NUM_LINES-1];
    logic [DATA_W-1:0]         tap_raw [NUM_LINES];
    logic [NUM_LINES*DATA_W-1:0] taps_next;

    assign accept     = valid_in && !clr;
    assign last_col   = (col == COL_W'(PIC_WIDTH - 1));
    assign lines_full = (lines_filled == LF_W'(NUM_LINES - 1));

    // Each memory shifts its old column value down one line while taking the one above.
    for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_line
        logic [DATA_W-1:0] mem [PIC_WIDTH];
        logic [DATA_W-1:0] wr_data;

        if (k == 0) begin : g_first
            assign wr_data = din;
        end else begin : g_chain
            assign wr_data = rd_data[k-1];
        end

        assign rd_data[k] = mem[col];

        always_ff @(posedge clk) begin
            if (accept) begin
                mem[col] <= wr_data;
            end
        end
    end

    always_comb begin
        tap_raw[0] = din;
        for (int k = 1; k < NUM_LINES; k++) begin
            tap_raw[k] = rd_data[k-1];
        end
    end

`ifdef LB_BORDER_REPLICATE_EN
    logic [DATA_W-1:0] edge_px;

    always_comb begin
        edge_px = tap_raw[0];
        for (int k = 1; k < NUM_LINES; k++) begin
            if (LF_W'(k) == lines_filled) begin
                edge_px = tap_raw[k];
            end
        end
    end
`endif

    // Taps beyond the lines seen since reset/clear would expose stale memory, so mask them.
    always_comb begin
        taps_next = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (k <= int'(lines_filled)) begin
                taps_next[k*DATA_W +: DATA_W] = tap_raw[k];
            end else begin
`ifdef LB_BORDER_REPLICATE_EN
                taps_next[k*DATA_W +: DATA_W] = edge_px;
`else
                taps_next[k*DATA_W +: DATA_W] = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            lines_filled <= '0;
        end else if (clr) begin
            col          <= '0;
            lines_filled <= '0;
        end else if (valid_in) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col && !lines_full) begin
                lines_filled <= lines_filled + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
            win_valid <= 1'b0;
            taps      <= '0;
            col_out   <= '0;
        end else begin
            valid_out <= accept;
            eol_out   <= accept && last_col;
            win_valid <= accept && lines_full;
            if (accept) begin
                taps    <= taps_next;
                col_out <= col;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_param.sv
// Scoreboard bench for line_buffer_param (DATA_W=8, PIC_WIDTH=4, NUM_LINES=3) against an image-row model.
// Build with LB_BORDER_REPLICATE_EN defined to check the replicate variant.
module tb_line_buffer_param;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] din = '0;
    logic          valid_out;
    logic [NL*DW-1:0] taps;
    logic [1:0]    col_out;
    logic          eol_out;
    logic          win_valid;

    line_buffer_param #(.DATA_W(DW), .PIC_WIDTH(PW), .NUM_LINES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .valid_in(valid_in), .din(din),
        .valid_out(valid_out), .taps(taps), .col_out(col_out),
        .eol_out(eol_out), .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*DW-1:0] taps;
        int               col;
        logic             eol;
        logic             win;
        int               cyc;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             n_checks = 0;
    int             n_fails = 0;
    logic [NL*DW-1:0] last_taps = '0;
    logic [DW-1:0]  hist [8][PW];
    int             m_row = 0;
    int             m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
    endtask

    // Window = same column of the current row and the rows above it in the current frame.
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        int   lf;
        hist[m_row % 8][m_col] = d;
        lf = (m_row < NL - 1) ? m_row : NL - 1;
        e.taps = '0;
        for (int k = 0; k < NL; k++) begin
            if (k <= lf) begin
                e.taps[k*DW +: DW] = hist[(m_row - k) % 8][m_col];
            end else begin
`ifdef LB_BORDER_REPLICATE_EN
                e.taps[k*DW +: DW] = hist[(m_row - lf) % 8][m_col];
`else
                e.taps[k*DW +: DW] = '0;
`endif
            end
        end
        e.col = m_col;
        e.eol = (m_col == PW - 1);
        e.win = (lf == NL - 1);
        e.cyc = cyc + 1;
        sb.push_back(e);
        m_col++;
        if (m_col == PW) begin
            m_col = 0;
            m_row++;
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic c, input logic [DW-1:0] d);
        valid_in = v;
        clr      = c;
        din      = d;
        if (c) model_reset();
        else if (v) model_accept(d);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        clr      = 1'b0;
        #1;
        check_output("async_reset", {valid_out, taps, col_out, eol_out, win_valid}, 32'h0);
        sb.delete();
        model_reset();
        last_taps = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_taps = '0;
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check_output("dropped_output", 32'(sb[0].cyc), 32'(cyc));
                void'(sb.pop_front());
            end
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check_output("spurious_valid", {31'h0, valid_out}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("taps", {8'h0, taps}, {8'h0, e.taps});
                    check_output("col_out", {30'h0, col_out}, 32'(e.col));
                    check_output("eol_win", {30'h0, eol_out, win_valid}, {30'h0, e.eol, e.win});
                    check_output("latency", 32'(cyc), 32'(e.cyc));
                    last_taps = e.taps;
                end
            end else begin
                check_output("hold_taps", {8'h0, taps}, {8'h0, last_taps});
                check_output("idle_flags", {30'h0, eol_out, win_valid}, 32'h0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", {valid_out, taps, col_out, eol_out, win_valid}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous 3 rows, with the two window spot checks.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < PW; c++) begin
                apply_stimulus(1'b1, 1'b0, DW'(16 * r + c));
                if (r == 0 && c == 2) begin
`ifdef LB_BORDER_REPLICATE_EN
                    check_output("row0_col2_taps", {8'h0, taps}, 32'h020202);
`else
                    check_output("row0_col2_taps", {8'h0, taps}, 32'h000002);
`endif
                    check_output("row0_col2_win", {31'h0, win_valid}, 32'h0);
                end
                if (r == 2 && c == 1) begin
                    check_output("row2_col1_taps", {8'h0, taps}, 32'h011121);
                    check_output("row2_col1_win", {31'h0, win_valid}, 32'h1);
                end
            end
        end
        apply_stimulus(1'b0, 1'b0, 8'h0);

        // Alternating valid_in.
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < PW; c++) begin
                apply_stimulus(1'b1, 1'b0, DW'(16 * r + c));
                apply_stimulus(1'b0, 1'b0, DW'($urandom));
            end
        end

        // Clear together with a pixel mid-row 1.
        pulse_reset();
        for (int c = 0; c < PW; c++) apply_stimulus(1'b1, 1'b0, DW'(c));
        apply_stimulus(1'b1, 1'b0, 8'h10);
        apply_stimulus(1'b1, 1'b0, 8'h11);
        apply_stimulus(1'b1, 1'b1, 8'h12);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < PW; c++) begin
                apply_stimulus(1'b1, 1'b0, DW'(8'h80 + 16 * r + c));
                if (r == 0 && c == 0) begin
                    check_output("post_clr_col", {30'h0, col_out}, 32'h0);
                    check_output("post_clr_win", {31'h0, win_valid}, 32'h0);
                end
            end
        end

        // Asynchronous reset mid-row 2, then a clean restart.
        pulse_reset();
        for (int i = 0; i < 2 * PW + 2; i++) apply_stimulus(1'b1, 1'b0, DW'(16 * (i / PW) + i % PW));
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < PW; c++) apply_stimulus(1'b1, 1'b0, DW'(16 * r + c));
        end

        // Five rows with lines_filled saturated.
        pulse_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < PW; c++) begin
                apply_stimulus(1'b1, 1'b0, DW'(16 * r + c));
                if (r == 4 && c == 3) begin
                    check_output("row4_col3_taps", {8'h0, taps}, 32'h233343);
                    check_output("row4_col3_eol", {31'h0, eol_out}, 32'h1);
                end
            end
        end

        // Randomized traffic with gaps and occasional clears.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), DW'($urandom));
        end

        repeat (3) apply_stimulus(1'b0, 1'b0, 8'h0);
        check_output("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
